// File: rtl/lct_l1a_matcher_if.sv
// lct_l1a_matcher_if: trigger-side bundle for the LCT/L1A matcher.
//   slave  modport: seen by the matcher (inputs lct, l1a, l1latency, window, cnt_clr;
//                   outputs l1a_match, l1acfeb, lcterr, filling and the three counters)
//   master modport: seen by whatever drives the trigger inputs and consumes the results
`timescale 1ns/1ps
interface lct_l1a_matcher_if;
  logic [5:0]  lct;        // bit0 any-LCT, bits5:1 per-CFEB LCT
  logic        l1a;        // level-1 accept, 1-cycle pulse
  logic [5:0]  l1latency;  // LCT delay setting, quasi-static
  logic [1:0]  window;     // match half-width in bunch crossings
  logic        cnt_clr;    // synchronous clear of all counters
  logic [4:0]  l1a_match;  // per-CFEB match bits, valid with l1acfeb
  logic        l1acfeb;    // delayed L1A pulse
  logic        lcterr;     // L1A found no any-LCT in its window
  logic        filling;    // delay pipeline refilling
  logic [15:0] l1a_cnt;    // saturating L1A count
  logic [15:0] match_cnt;  // saturating matched-L1A count
  logic [15:0] err_cnt;    // saturating LCT-missing count

  modport master (
    output lct, l1a, l1latency, window, cnt_clr,
    input  l1a_match, l1acfeb, lcterr, filling, l1a_cnt, match_cnt, err_cnt
  );

  modport slave (
    input  lct, l1a, l1latency, window, cnt_clr,
    output l1a_match, l1acfeb, lcterr, filling, l1a_cnt, match_cnt, err_cnt
  );
endinterface

// File: rtl/lct_l1a_matcher.sv
// lct_l1a_matcher: delays raw LCT bits by a programmable L1 latency and matches every
// L1A against the delayed LCTs inside a +/-W bunch-crossing window.
// Ports:
//   clk  - 40 MHz CMS clock, single domain
//   rst  - synchronous active-high reset
//   bus  - lct_l1a_matcher_if.slave: trigger inputs, match/pulse/error outputs, counters
// Timing: an L1A sampled in cycle t yields l1acfeb in cycle t+W+2, matched against LCT
// input cycles t-1-L-W .. t-1-L+W, with L = max(l1latency,1) clamped to DEPTH.
`timescale 1ns/1ps
module lct_l1a_matcher #(
  parameter int DEPTH  = 64,
  parameter int MAXWIN = 3,
  parameter bit TMR    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  lct_l1a_matcher_if.slave bus
);

  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = (AW >= 6) ? AW + 1 : 7;
  localparam int SRD      = 2 * MAXWIN + 1;
  localparam int FILL_LEN = DEPTH + 2 * MAXWIN + 2;
  localparam int CW       = $clog2(FILL_LEN + 1);

  typedef enum logic {RUN = 1'b0, FILL = 1'b1} state_t;

  function automatic logic [AW-1:0] vote_ptr(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                             input logic [AW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [CW-1:0] vote_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic [CW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic vote_bit(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    if (en && (cnt != 16'hFFFF)) return cnt + 16'd1;
    else return cnt;
  endfunction

  logic [5:0]    lct_r;
  logic          l1a_r;
  logic [MAXWIN:1] l1a_pipe_r;
  logic [5:0]    lat_q_r;
  logic [1:0]    win_q_r;
  logic [AW-1:0] wptr_r [3];
  state_t        state_r [3];
  logic [CW-1:0] fcnt_r [3];
  logic          filling_r;
  logic [5:0]    dbuf_r [DEPTH];
  logic [5:0]    sr_r [SRD];
  logic          l1acfeb_r;
  logic [4:0]    match_r;
  logic          err_r;
  logic [15:0]   l1a_cnt_r;
  logic [15:0]   match_cnt_r;
  logic [15:0]   err_cnt_r;

  logic [AW-1:0] wptr_s;
  state_t        state_s;
  logic [CW-1:0] fcnt_s;
  logic [LW-1:0] lat_ext_s;
  logic [AW-1:0] lat_eff_s;
  logic [AW-1:0] rd_ptr_s;
  logic [5:0]    dlct_s;
  logic [1:0]    w_eff_s;
  logic [5:0]    win_or_s;
  logic [MAXWIN:0] l1a_vec_s;
  logic          l1a_sel_s;
  logic          cfg_chg_s;

  // With TMR the three copies are voted; otherwise copy 0 is the only live one.
  assign wptr_s  = TMR ? vote_ptr(wptr_r[0], wptr_r[1], wptr_r[2]) : wptr_r[0];
  assign fcnt_s  = TMR ? vote_cnt(fcnt_r[0], fcnt_r[1], fcnt_r[2]) : fcnt_r[0];
  assign state_s = TMR ? state_t'(vote_bit(state_r[0], state_r[1], state_r[2])) : state_r[0];

  // Effective latency; a delay of exactly DEPTH maps to offset 0, i.e. the slot about to be overwritten.
  always_comb begin
    lat_ext_s = LW'(bus.l1latency);
    if (lat_ext_s == {LW{1'b0}}) begin
      lat_eff_s = AW'(1'b1);
    end else if (lat_ext_s >= LW'(DEPTH)) begin
      lat_eff_s = {AW{1'b0}};
    end else begin
      lat_eff_s = lat_ext_s[AW-1:0];
    end
  end

  assign rd_ptr_s  = wptr_s - lat_eff_s;
  assign dlct_s    = dbuf_r[rd_ptr_s];
  assign w_eff_s   = (bus.window > 2'(MAXWIN)) ? 2'(MAXWIN) : bus.window;
  assign cfg_chg_s = (bus.l1latency != lat_q_r) || (bus.window != win_q_r);

  // l1a_vec_s[k] holds the L1A sampled k+1 cycles ago; picking k=W lines it up with a centred window.
  assign l1a_vec_s = {l1a_pipe_r, l1a_r};
  assign l1a_sel_s = l1a_vec_s[w_eff_s];

  // OR of the delayed LCTs over the 2W+1 newest shift-register taps.
  always_comb begin
    win_or_s = 6'b000000;
    for (int j = 0; j < SRD; j++) begin
      if (j <= 2 * int'(w_eff_s)) begin
        win_or_s = win_or_s | sr_r[j];
      end else begin
        win_or_s = win_or_s;
      end
    end
  end

  // Input registers, L1A alignment pipe and write pointer; reset drops in-flight L1As.
  always_ff @(posedge clk) begin
    if (rst) begin
      lct_r      <= 6'b000000;
      l1a_r      <= 1'b0;
      l1a_pipe_r <= '0;
      for (int i = 0; i < 3; i++) wptr_r[i] <= {AW{1'b0}};
    end else begin
      lct_r         <= bus.lct;
      l1a_r         <= bus.l1a;
      l1a_pipe_r[1] <= l1a_r;
      for (int k = 2; k <= MAXWIN; k++) l1a_pipe_r[k] <= l1a_pipe_r[k-1];
      for (int i = 0; i < 3; i++) wptr_r[i] <= wptr_s + AW'(1'b1);
    end
  end

  // Registered copy of the configuration, loaded during reset so reset exit is not seen as a change.
  always_ff @(posedge clk) begin
    lat_q_r <= bus.l1latency;
    win_q_r <= bus.window;
  end

  // Delay buffer and window shift register; contents are masked by FILL, so no reset.
  always_ff @(posedge clk) begin
    dbuf_r[wptr_s] <= lct_r;
    sr_r[0]        <= dlct_s;
    for (int j = 1; j < SRD; j++) sr_r[j] <= sr_r[j-1];
  end

  // RUN/FILL state machine: any config change (re)starts a full refill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= FILL;
        fcnt_r[i]  <= {CW{1'b0}};
      end
      filling_r <= 1'b1;
    end else begin
      case (state_s)
        RUN: begin
          for (int i = 0; i < 3; i++) begin
            state_r[i] <= cfg_chg_s ? FILL : RUN;
            fcnt_r[i]  <= {CW{1'b0}};
          end
          filling_r <= cfg_chg_s;
        end
        FILL: begin
          if (cfg_chg_s) begin
            for (int i = 0; i < 3; i++) begin
              state_r[i] <= FILL;
              fcnt_r[i]  <= {CW{1'b0}};
            end
            filling_r <= 1'b1;
          end else if (fcnt_s == CW'(FILL_LEN - 1)) begin
            for (int i = 0; i < 3; i++) begin
              state_r[i] <= RUN;
              fcnt_r[i]  <= {CW{1'b0}};
            end
            filling_r <= 1'b0;
          end else begin
            for (int i = 0; i < 3; i++) begin
              state_r[i] <= FILL;
              fcnt_r[i]  <= fcnt_s + CW'(1'b1);
            end
            filling_r <= 1'b1;
          end
        end
        default: begin
          for (int i = 0; i < 3; i++) begin
            state_r[i] <= FILL;
            fcnt_r[i]  <= {CW{1'b0}};
          end
          filling_r <= 1'b1;
        end
      endcase
    end
  end

  // Result registers: during FILL the pulse still goes out but match/error are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1acfeb_r <= 1'b0;
      match_r   <= 5'b00000;
      err_r     <= 1'b0;
    end else begin
      l1acfeb_r <= l1a_sel_s;
      if (l1a_sel_s && (state_s == RUN)) begin
        match_r <= win_or_s[5:1];
        err_r   <= ~win_or_s[0];
      end else begin
        match_r <= 5'b00000;
        err_r   <= 1'b0;
      end
    end
  end

  // Saturating counters driven by the registered results; clear takes priority over increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      l1a_cnt_r   <= 16'h0000;
      match_cnt_r <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      l1a_cnt_r   <= sat_inc(l1a_cnt_r, l1acfeb_r);
      match_cnt_r <= sat_inc(match_cnt_r, l1acfeb_r && (match_r != 5'b00000));
      err_cnt_r   <= sat_inc(err_cnt_r, err_r);
    end
  end

  assign bus.l1a_match = match_r;
  assign bus.l1acfeb   = l1acfeb_r;
  assign bus.lcterr    = err_r;
  assign bus.filling   = filling_r;
  assign bus.l1a_cnt   = l1a_cnt_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule
